// File: rtl/button_debouncer.sv
// Button conditioner: two-flop synchronizer, debounce FSM, level output,
// and registered press/release/long-press strobes for one active-low pin.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES   = 120000,
  parameter int unsigned LONG_PRESS_CYCLES = 12000000,
  parameter int unsigned CNT_W             = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_FIRE = CNT_W'(LONG_PRESS_CYCLES - 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             s1_q, s2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] deb_q, deb_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;

  // Inversion at s1 so the synchronized value reads 1 = pressed; reset holds released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= ~btn_n;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RELEASED;
      deb_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    hold_d  = hold_q;
    case (state_q)
      RELEASED: begin
        if (s2_q) begin
          state_d = PRESS_WAIT;
          deb_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2_q) begin
          state_d = RELEASED;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = PRESSED;
          deb_d   = '0;
          hold_d  = '0;
        end else begin
          deb_d = deb_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (hold_q != HOLD_LAST) hold_d = hold_q + CNT_ONE;
        if (!s2_q) begin
          state_d = RELEASE_WAIT;
          deb_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // hold_q is left untouched here so a release glitch resumes the long-press timer
        if (s2_q) begin
          state_d = PRESSED;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = RELEASED;
          deb_d   = '0;
          hold_d  = '0;
        end else begin
          deb_d = deb_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        deb_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      PRESS_WAIT: begin
        if (s2_q && deb_q == DEB_LAST) begin
          level_d = 1'b1;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (hold_q == HOLD_FIRE) long_d = 1'b1;
      end
      RELEASE_WAIT: begin
        if (!s2_q && deb_q == DEB_LAST) begin
          level_d   = 1'b0;
          release_d = 1'b1;
        end
      end
      RELEASED: ;
      default: level_d = 1'b0;
    endcase
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10.
module tb_button_debouncer;

  localparam int unsigned DEB = 4;
  localparam int unsigned LP  = 10;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic btn_n = 1'b1;
  logic btn_level, press_pulse, release_pulse, long_press;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int edge_no    = 0;
  int press_cnt  = 0;
  int rel_cnt    = 0;
  int long_cnt   = 0;
  int press_edge = 0;
  int multi_cnt  = 0;

  always #5 clk = ~clk;

  button_debouncer #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LP),
    .CNT_W            (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_n        (btn_n),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_press   (long_press)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // One clock edge; outputs are sampled 1 ns after it and strobes tallied.
  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
    if (press_pulse) begin
      press_cnt++;
      press_edge = edge_no;
    end
    if (release_pulse) rel_cnt++;
    if (long_press) long_cnt++;
    if (int'(press_pulse) + int'(release_pulse) + int'(long_press) > 1) multi_cnt++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic new_phase();
    edge_no   = 0;
    press_cnt = 0;
    rel_cnt   = 0;
    long_cnt  = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step();
    check("rst_level", btn_level, 0);
    check("rst_press", press_pulse, 0);
    check("rst_release", release_pulse, 0);
    check("rst_long", long_press, 0);
    rst = 1'b0;
    steps(2);

    // Clean press: accepted at edge 7, long press 9 edges later
    new_phase();
    btn_n = 1'b0;
    steps(6);
    check("t1_level_e6", btn_level, 0);
    check("t1_presscnt_e6", press_cnt, 0);
    step();
    check("t1_press_e7", press_pulse, 1);
    check("t1_level_e7", btn_level, 1);
    step();
    check("t1_press_e8", press_pulse, 0);
    steps(7);
    check("t3_long_e15", long_press, 0);
    step();
    check("t3_long_e16", long_press, 1);
    step();
    check("t3_long_e17", long_press, 0);
    steps(50);
    check("t3_long_once", long_cnt, 1);
    check("t1_press_once", press_cnt, 1);
    check("t1_no_release", rel_cnt, 0);
    check("t3_level_held", btn_level, 1);

    // Clean release
    new_phase();
    btn_n = 1'b1;
    steps(6);
    check("rel1_level_e6", btn_level, 1);
    check("rel1_relcnt_e6", rel_cnt, 0);
    step();
    check("rel1_release_e7", release_pulse, 1);
    check("rel1_level_e7", btn_level, 0);
    step();
    check("rel1_release_e8", release_pulse, 0);
    steps(3);

    // Bouncy press: final steady low first sampled at edge 7 -> press at 13
    new_phase();
    btn_n = 1'b0; steps(2);
    btn_n = 1'b1; step();
    btn_n = 1'b0; steps(2);
    btn_n = 1'b1; step();
    btn_n = 1'b0; steps(6);
    check("t2_presscnt_e12", press_cnt, 0);
    check("t2_level_e12", btn_level, 0);
    step();
    check("t2_press_e13", press_pulse, 1);
    check("t2_press_edge", press_edge, 13);

    // Release glitch two edges into PRESSED; two cycles in RELEASE_WAIT delay long press to 24
    steps(2);
    btn_n = 1'b1; steps(2);
    btn_n = 1'b0; steps(5);
    check("t4_level_e22", btn_level, 1);
    check("t4_relcnt_e22", rel_cnt, 0);
    check("t4_longcnt_e22", long_cnt, 0);
    step();
    check("t4_long_e23", long_press, 0);
    step();
    check("t4_long_e24", long_press, 1);
    check("t4_press_once", press_cnt, 1);

    new_phase();
    btn_n = 1'b1;
    steps(6);
    check("t4_relcnt_e6", rel_cnt, 0);
    step();
    check("t4_release_e7", release_pulse, 1);
    check("t4_level_e7", btn_level, 0);
    steps(3);

    // Reset during PRESS_WAIT with the button held
    new_phase();
    btn_n = 1'b0;
    steps(4);
    rst = 1'b1;
    #1;
    check("t5_rst_level", btn_level, 0);
    check("t5_rst_press", press_pulse, 0);
    steps(2);
    check("t5_rst_level2", btn_level, 0);
    check("t5_rst_presscnt", press_cnt, 0);
    rst = 1'b0;
    new_phase();
    steps(6);
    check("t5_presscnt_e6", press_cnt, 0);
    step();
    check("t5_press_e7", press_pulse, 1);
    check("t5_level_e7", btn_level, 1);
    steps(5);
    check("t5_press_once", press_cnt, 1);
    check("t5_no_release", rel_cnt, 0);
    btn_n = 1'b1;
    steps(12);
    check("t5_released", btn_level, 0);

    // Short tap of three samples is rejected
    new_phase();
    btn_n = 1'b0; steps(3);
    btn_n = 1'b1; steps(20);
    check("t6_no_press", press_cnt, 0);
    check("t6_no_release", rel_cnt, 0);
    check("t6_level", btn_level, 0);
    // A fresh press still qualifies at edge 7, so the FSM returned to RELEASED
    new_phase();
    btn_n = 1'b0; steps(8);
    check("t6_next_press_cnt", press_cnt, 1);
    check("t6_next_press_edge", press_edge, 7);

    check("strobes_exclusive", multi_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
